uart_rx: RTL

Oversampling UART receiver. It is the receive end of the serial link whose bit timing comes from baud_gen.
- Consumes baud_gen's rx_clk as a single-cycle sample enable at BAUD*OVERSAMPLE_TIME.
- Recovers 8N1 frames from the asynchronous rx line.
- Presents each byte on a valid/ready output register, with framing and overrun error pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit blocks.
//   uart_state_t   - receiver FSM states (PARITY only reached when the
//                    UART_RX_PARITY_EN build option is defined)
//   MIN_OVERSAMPLE - smallest legal oversample ratio
//   oversample_ok  - elaboration-time legality check for OVERSAMPLE_TIME
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } uart_state_t;

  localparam int MIN_OVERSAMPLE = 4;

  // Mid-bit sampling needs an even ratio of at least MIN_OVERSAMPLE.
  function automatic bit oversample_ok(input int os);
    return (os >= MIN_OVERSAMPLE) && ((os % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous, idle-high line.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (both flops reset to 1 = idle)
//   d     in  asynchronous input
//   q     out synchronised output
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8N1 by default).
// Build option: UART_RX_PARITY_EN adds a parity bit between data and stop,
// checked against PARITY_ODD, and the parity_err output.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx_tick       oversample enable from baud_gen, one clk wide
//   rx            serial line, idle high, asynchronous
//   rx_data       received byte, stable while rx_valid
//   rx_valid      byte available, held until rx_ready
//   rx_ready      consumer accept
//   busy          high from start-bit detect until back in IDLE
//   frame_err     one-cycle pulse: stop bit sampled low
//   overrun_err   one-cycle pulse: good frame dropped, old byte not taken
//   parity_err    (parity build only) one-cycle pulse at stop-sample time
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE_TIME = 8,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE_TIME);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE_TIME / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE_TIME - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  generate
    if (!oversample_ok(OVERSAMPLE_TIME) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx: illegal OVERSAMPLE_TIME or PARITY_ODD");
    end
  endgenerate

  logic                 rxs;
  uart_state_t          state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 t_last;
  logic                 stop_hit;
  logic                 par_ok;
  logic                 good_byte;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Data ones plus parity bit must have odd/even weight matching PARITY_ODD.
  assign par_ok = (^shreg ^ par_bit) == 1'(PARITY_ODD);
`else
  assign par_ok = 1'b1;
`endif

  assign t_last    = (tcnt == T_LAST);
  assign stop_hit  = rx_tick && (state == STOP) && t_last;
  assign good_byte = stop_hit && rxs && par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif

      // Output register: a same-cycle handshake frees the slot for a new byte.
      if (good_byte && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (good_byte) overrun_err <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end

      if (rx_tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              tcnt  <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (tcnt == T_MID) begin
              if (!rxs) begin
                state <= DATA;
                tcnt  <= '0;
                bcnt  <= '0;
              end else begin
                // Start bit gone by mid-bit: treat as line noise.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DATA: begin
            if (t_last) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              tcnt  <= '0;
              bcnt  <= bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
              if (bcnt == B_LAST) state <= PARITY;
`else
              if (bcnt == B_LAST) state <= STOP;
`endif
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (t_last) begin
              par_bit <= rxs;
              tcnt    <= '0;
              state   <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (t_last) begin
              tcnt <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err <= !par_ok;
`endif
              if (rxs) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          BRK: begin
            // Hold off until the line returns high so a stuck-low line
            // reports one framing error only.
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
